// File: rtl/screen_fill_arbiter_pkg.sv
// screen_pkg: shared states, colours, screen geometry and pixel request type
// for the frame-buffer plot arbiter.
package screen_pkg;

    typedef enum logic [1:0] {IDLE, FILL, PIX, DONE} state_t;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam int SCREEN_NX = 8;
    localparam int SCREEN_NY = 7;
    localparam int SCREEN_MAX_X = 159;
    localparam int SCREEN_MAX_Y = 119;

    typedef struct packed {
        logic [SCREEN_NX-1:0] x;
        logic [SCREEN_NY-1:0] y;
        logic [2:0]           color;
    } pix_req_t;

    function automatic logic in_range(input int px, input int py, input int mx, input int my);
        return (px <= mx) && (py <= my);
    endfunction

endpackage

// File: rtl/screen_fill_arbiter_if.sv
// screen_fill_arbiter_if: fill control, pixel handshake and frame-buffer plot bus.
// FILL_ABORT_EN adds the fill_abort request line.
interface screen_fill_arbiter_if #(
    parameter int NX = 8,
    parameter int NY = 7
);
    logic          fill_start;
    logic          fill_mode;
    logic          fill_busy;
    logic          fill_done;
`ifdef FILL_ABORT_EN
    logic          fill_abort;
`endif
    logic          pix_valid;
    logic          pix_ready;
    logic [NX-1:0] pix_x;
    logic [NY-1:0] pix_y;
    logic [2:0]    pix_color;
    logic          plot;
    logic [NX-1:0] x;
    logic [NY-1:0] y;
    logic [2:0]    color;

`ifdef FILL_ABORT_EN
    modport slave (
        input  fill_start, fill_mode, fill_abort, pix_valid, pix_x, pix_y, pix_color,
        output fill_busy, fill_done, pix_ready, plot, x, y, color
    );
    modport master (
        output fill_start, fill_mode, fill_abort, pix_valid, pix_x, pix_y, pix_color,
        input  fill_busy, fill_done, pix_ready, plot, x, y, color
    );
`else
    modport slave (
        input  fill_start, fill_mode, pix_valid, pix_x, pix_y, pix_color,
        output fill_busy, fill_done, pix_ready, plot, x, y, color
    );
    modport master (
        output fill_start, fill_mode, pix_valid, pix_x, pix_y, pix_color,
        input  fill_busy, fill_done, pix_ready, plot, x, y, color
    );
`endif

endinterface

// File: rtl/screen_fill_arbiter_xy_scan_counter.sv
// xy_scan_counter: x-fastest raster counter over a (MAX_X+1) x (MAX_Y+1) screen;
// last flags the final pixel so the owner can stop after presenting it.
module xy_scan_counter #(
    parameter int NX    = 8,
    parameter int NY    = 7,
    parameter int MAX_X = 159,
    parameter int MAX_Y = 119
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          en,
    output logic [NX-1:0] x,
    output logic [NY-1:0] y,
    output logic          last
);

    localparam logic [NX-1:0] LX = NX'(MAX_X);
    localparam logic [NY-1:0] LY = NY'(MAX_Y);

    logic [NX-1:0] x_q, x_d;
    logic [NY-1:0] y_q, y_d;
    logic          x_wrap;

    // Equality wraps keep the counters inside NX/NY bits without overflow.
    always_comb begin
        x_wrap = x_q == LX;
        x_d    = clear ? '0 : en ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d    = clear ? '0 : (en && x_wrap) ? ((y_q == LY) ? '0 : y_q + 1'b1) : y_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_wrap && (y_q == LY);

endmodule

// File: rtl/screen_fill_arbiter.sv
// screen_fill_arbiter: shares the frame-buffer plot port between a full-screen
// fill engine and a single-pixel valid/ready port. FILL_ABORT_EN adds fill_abort.
module screen_fill_arbiter
    import screen_pkg::*;
#(
    parameter int NX    = 8,
    parameter int NY    = 7,
    parameter int MAX_X = SCREEN_MAX_X,
    parameter int MAX_Y = SCREEN_MAX_Y
) (
    input logic                  clk,
    input logic                  reset_n,
    screen_fill_arbiter_if.slave bus
);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          last_q, last_d;
    logic          plot_q, plot_d;
    logic [NX-1:0] x_q, x_d;
    logic [NY-1:0] y_q, y_d;
    logic [2:0]    color_q, color_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scan_clear, scan_en, scan_last, abort;
    logic [NX-1:0] scan_x;
    logic [NY-1:0] scan_y;

`ifdef FILL_ABORT_EN
    assign abort = bus.fill_abort;
`else
    assign abort = 1'b0;
`endif

    xy_scan_counter #(.NX(NX), .NY(NY), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) u_scan (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (scan_clear),
        .en     (scan_en),
        .x      (scan_x),
        .y      (scan_y),
        .last   (scan_last)
    );

    // The scan counter runs one pixel ahead of the plot registers; last_q marks
    // that the registers currently present the final fill pixel.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        last_d     = 1'b0;
        plot_d     = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        color_d    = color_q;
        done_d     = 1'b0;
        scan_clear = 1'b0;
        scan_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    state_d = FILL;
                    mode_d  = bus.fill_mode;
                    scan_en = 1'b1;
                end else begin
                    scan_clear = 1'b1;
                    if (bus.pix_valid) begin
                        state_d = PIX;
                        plot_d  = in_range(int'(bus.pix_x), int'(bus.pix_y), MAX_X, MAX_Y);
                        x_d     = bus.pix_x;
                        y_d     = bus.pix_y;
                        color_d = bus.pix_color;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    state_d    = IDLE;
                    scan_clear = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                end else if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    scan_en = 1'b1;
                end
            end
            PIX:     state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (scan_en) begin
            plot_d  = 1'b1;
            x_d     = scan_x;
            y_d     = scan_y;
            color_d = mode_d ? scan_y[2:0] : COLOR_BLACK;
            last_d  = scan_last;
        end
        busy_d = state_d == FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pix_ready = reset_n && (state_q == IDLE) && !bus.fill_start;
    assign bus.plot      = plot_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.color     = color_q;
    assign bus.fill_busy = busy_q;
    assign bus.fill_done = done_q;

endmodule

// File: tb/tb_screen_fill_arbiter.sv
// tb_screen_fill_arbiter: directed stimulus with a scoreboard queue of expected
// plot writes and done pulses, drained by an independent monitor.
module tb_screen_fill_arbiter;
    import screen_pkg::*;

    typedef struct packed {
        logic     done;
        pix_req_t px;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    screen_fill_arbiter_if #(.NX(8), .NY(7)) bus ();

    screen_fill_arbiter dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic m, input int cnt, input bit with_done);
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.done     = 1'b0;
            e.px.x     = 8'(i % 160);
            e.px.y     = 7'(i / 160);
            e.px.color = m ? 3'(i / 160) : 3'b000;
            q.push_back(e);
        end
        if (with_done) q.push_back('{done: 1'b1, px: '0});
    endtask

    // Monitor: every plot strobe or done pulse must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n && (bus.plot || bus.fill_done)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got plot=%0b done=%0b x=%0d y=%0d c=%0d expected=nothing",
                         bus.plot, bus.fill_done, bus.x, bus.y, bus.color);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.fill_done !== e.done || bus.plot !== !e.done ||
                    (!e.done && (bus.x !== e.px.x || bus.y !== e.px.y || bus.color !== e.px.color))) begin
                    failures++;
                    $display("FAIL sb_write got plot=%0b done=%0b x=%0d y=%0d c=%0d expected done=%0b x=%0d y=%0d c=%0d",
                             bus.plot, bus.fill_done, bus.x, bus.y, bus.color,
                             e.done, e.px.x, e.px.y, e.px.color);
                end
            end
        end
    end

    task automatic do_fill(input logic m, input bit with_pix);
        int  n, c;
        bit  seen, pw;
        @(negedge clk);
        bus.fill_start = 1'b1;
        bus.fill_mode  = m;
        if (with_pix) begin
            bus.pix_valid = 1'b1;
            bus.pix_x     = 8'd20;
            bus.pix_y     = 7'd30;
            bus.pix_color = 3'd6;
        end
        #1 chk("start_ready_low", bus.pix_ready, 0);
        push_fill(m, 19200, 1'b1);
        if (with_pix) q.push_back('{done: 1'b0, px: '{x: 8'd20, y: 7'd30, color: 3'd6}});
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.fill_mode  = !m;
        chk("fill_first", {bus.plot, bus.x, bus.y}, {1'b1, 8'd0, 7'd0});
        chk("fill_busy_first", bus.fill_busy, 1);
        n = 0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20000) begin
            if (bus.plot) n++;
            if (bus.fill_done) seen = 1'b1;
            else begin
                pw = bus.plot && bus.x == 8'd159 && bus.y == 7'd10;
                @(negedge clk);
                c++;
                if (pw) chk("wrap_x_y", {bus.x, bus.y}, {8'd0, 7'd11});
            end
        end
        chk("fill_plots", n, 19200);
        chk("fill_done_cycle", c, 19200);
        chk("done_busy_low", bus.fill_busy, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.fill_done, 0);
        chk("idle_ready", bus.pix_ready, 1);
        if (with_pix) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            chk("held_pix_plot", bus.plot, 1);
            @(negedge clk);
        end
    endtask

    task automatic do_pix(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc, input logic exp);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_x     = px;
        bus.pix_y     = py;
        bus.pix_color = pc;
        #1 chk("pix_ready", bus.pix_ready, 1);
        if (exp) q.push_back('{done: 1'b0, px: '{x: px, y: py, color: pc}});
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("pix_plot", bus.plot, exp);
        @(negedge clk);
        chk("pix_back_idle", {bus.plot, bus.pix_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        int c;
        bus.fill_start = 1'b0;
        bus.fill_mode  = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_x      = '0;
        bus.pix_y      = '0;
        bus.pix_color  = '0;
`ifdef FILL_ABORT_EN
        bus.fill_abort = 1'b0;
`endif
        #3;
        chk("rst_plot", bus.plot, 0);
        chk("rst_xy", {bus.x, bus.y}, 0);
        chk("rst_color", bus.color, 0);
        chk("rst_busy_done", {bus.fill_busy, bus.fill_done}, 0);
        chk("rst_ready", bus.pix_ready, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready_initial", bus.pix_ready, 1);

        do_fill(1'b0, 1'b0);
        do_fill(1'b1, 1'b1);

        do_pix(8'd5, 7'd7, 3'b101, 1'b1);
        do_pix(8'd160, 7'd0, 3'b001, 1'b0);
        do_pix(8'd159, 7'd119, 3'b111, 1'b1);
        do_pix(8'd0, 7'd120, 3'b010, 1'b0);

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.fill_start = 1'b1;
        bus.fill_mode  = 1'b1;
        push_fill(1'b1, 19200, 1'b1);
        @(negedge clk);
        bus.fill_start = 1'b0;
        c = 0;
        while (!(bus.plot && bus.x == 8'd80 && bus.y == 7'd60) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_80_60", c, 9680);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_out", {bus.plot, bus.x, bus.y, bus.fill_busy}, 0);
        q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", bus.fill_done, 0);
        bus.fill_start = 1'b1;
        bus.fill_mode  = 1'b0;
        push_fill(1'b0, 19200, 1'b1);
        @(negedge clk);
        bus.fill_start = 1'b0;
        chk("refill_first", {bus.plot, bus.x, bus.y}, {1'b1, 8'd0, 7'd0});
        repeat (5) @(negedge clk);
        chk("refill_progress", {bus.plot, bus.x, bus.y}, {1'b1, 8'd5, 7'd0});
        #2 reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;

`ifdef FILL_ABORT_EN
        @(negedge clk);
        bus.fill_start = 1'b1;
        bus.fill_mode  = 1'b0;
        push_fill(1'b0, 331, 1'b0);
        @(negedge clk);
        bus.fill_start = 1'b0;
        c = 0;
        while (!(bus.plot && bus.x == 8'd10 && bus.y == 7'd2) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reach", c, 330);
        bus.fill_abort = 1'b1;
        @(negedge clk);
        bus.fill_abort = 1'b0;
        chk("abort_stop", {bus.plot, bus.fill_busy, bus.fill_done}, 0);
        chk("abort_xy", {bus.x, bus.y}, 0);
        chk("abort_ready", bus.pix_ready, 1);
        repeat (3) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
